// File: rtl/singles_frame_decoder_pkg.sv
// Frame layout shared by the singles decoder and the detector-side encoder.
// A frame is 128 bits sent MSB byte first; frame bit 127 is byte 0 bit 7.
package singles_frame_decoder_pkg;

  localparam logic [4:0]  FRAMING    = 5'b11111;
  localparam int unsigned FLAG_BIT   = 122;
  localparam int unsigned BLOCK_LSB  = 116;
  localparam int unsigned BLOCK_W    = 6;
  localparam int unsigned ENERGY_LSB = 20;
  localparam int unsigned ENERGY_W   = 12;
  localparam int unsigned N_CHANNELS = 8;
  localparam int unsigned TIME_LSB   = 0;
  localparam int unsigned TIME_W     = 20;
  localparam int unsigned ESUM_W     = 15;

  typedef enum logic [1:0] {
    HUNT,
    CHECK,
    LOCKED
  } align_state_t;

  // Takes the top five bits of a link byte.
  function automatic logic is_header(input logic [4:0] hi);
    return hi == FRAMING;
  endfunction

endpackage

// File: rtl/singles_frame_decoder_frame_aligner.sv
// Byte-stream frame aligner: finds header bytes, qualifies lock over
// consecutive frames, and flags the last byte of each trusted frame.
module frame_aligner
  import singles_frame_decoder_pkg::*;
#(
  parameter int unsigned FRAME_BYTES = 16,
  parameter int unsigned LOCK_GOOD   = 2,
  parameter int unsigned LOCK_MISS   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        header,
  input  logic        accept,
  output logic        locked,
  output logic        frame_done,
  output logic [15:0] frame_errors
);

  localparam int unsigned CNT_W  = $clog2(FRAME_BYTES);
  localparam int unsigned GOOD_W = $clog2(LOCK_GOOD + 1);
  localparam int unsigned MISS_W = $clog2(LOCK_MISS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_BYTES - 1);

  align_state_t      state;
  logic [CNT_W-1:0]  count;
  logic [GOOD_W-1:0] good;
  logic [MISS_W-1:0] miss;
  logic              armed;

  // The frame whose header completes lock was started before lock was
  // established, so only frames whose header arrives in LOCKED are emitted.
  assign frame_done = accept && (state == LOCKED) && armed && (count == LAST);

  // Alignment FSM, byte counter and error statistics; advances only on accepted bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= HUNT;
      count        <= '0;
      good         <= '0;
      miss         <= '0;
      armed        <= 1'b0;
      locked       <= 1'b0;
      frame_errors <= '0;
    end else if (accept) begin
      unique case (state)
        HUNT: begin
          if (header) begin
            state <= CHECK;
            count <= CNT_W'(1);
            good  <= GOOD_W'(1);
          end
        end
        CHECK: begin
          if (count == '0) begin
            if (header) begin
              count <= CNT_W'(1);
              good  <= good + GOOD_W'(1);
              if (good + GOOD_W'(1) == GOOD_W'(LOCK_GOOD)) begin
                state  <= LOCKED;
                locked <= 1'b1;
                armed  <= 1'b0;
              end
            end else begin
              state <= HUNT;
              good  <= '0;
            end
          end else begin
            count <= (count == LAST) ? '0 : count + CNT_W'(1);
          end
        end
        LOCKED: begin
          if (count == '0) begin
            if (header) begin
              count <= CNT_W'(1);
              miss  <= '0;
              armed <= 1'b1;
            end else begin
              if (frame_errors != '1) frame_errors <= frame_errors + 16'd1;
              if (miss + MISS_W'(1) == MISS_W'(LOCK_MISS)) begin
                state  <= HUNT;
                locked <= 1'b0;
                armed  <= 1'b0;
                miss   <= '0;
                good   <= '0;
              end else begin
                miss <= miss + MISS_W'(1);
              end
            end
          end else begin
            count <= (count == LAST) ? '0 : count + CNT_W'(1);
          end
        end
        default: begin
          state  <= HUNT;
          count  <= '0;
          good   <= '0;
          miss   <= '0;
          armed  <= 1'b0;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/singles_frame_decoder.sv
// Singles frame decoder: aligns the link byte stream into 128-bit frames,
// unpacks the fields and presents them with the energy sum over a
// valid/ready output that back-pressures the link.
module singles_frame_decoder
  import singles_frame_decoder_pkg::*;
#(
  parameter int unsigned FRAME_BYTES = 16,
  parameter int unsigned LOCK_GOOD   = 2,
  parameter int unsigned LOCK_MISS   = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [7:0]                     in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_single,
  output logic [BLOCK_W-1:0]             out_block_id,
  output logic [N_CHANNELS*ENERGY_W-1:0] out_energy,
  output logic [TIME_W-1:0]              out_time,
  output logic [ESUM_W-1:0]              out_esum,
  output logic                           locked,
  output logic [15:0]                    frame_errors
);

  // Framing bits above the flag are already vetted by the aligner, so the
  // shift register only keeps the bits that reach the outputs.
  localparam int unsigned USED_W = FLAG_BIT + 1;
  localparam int unsigned SR_W   = USED_W - 8;

  logic              accept;
  logic              frame_done;
  logic [SR_W-1:0]   shift;
  logic [USED_W-1:0] frame;
  logic [ESUM_W-1:0] esum_next;

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign frame    = {shift, in_data};

  frame_aligner #(
    .FRAME_BYTES (FRAME_BYTES),
    .LOCK_GOOD   (LOCK_GOOD),
    .LOCK_MISS   (LOCK_MISS)
  ) u_aligner (
    .clk          (clk),
    .rst          (rst),
    .header       (is_header(in_data[7:3])),
    .accept       (accept),
    .locked       (locked),
    .frame_done   (frame_done),
    .frame_errors (frame_errors)
  );

  // Byte shift register holding the frame assembled so far.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) shift <= '0;
    else if (accept) shift <= frame[SR_W-1:0];
  end

  // Energy sum of the frame completing this cycle, zero-extended so it cannot overflow.
  always_comb begin
    esum_next = '0;
    for (int unsigned i = 0; i < N_CHANNELS; i++) begin
      esum_next = esum_next + ESUM_W'(frame[ENERGY_LSB + i*ENERGY_W +: ENERGY_W]);
    end
  end

  // Output register: loads on a trusted frame, holds until the consumer takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_single   <= 1'b0;
      out_block_id <= '0;
      out_energy   <= '0;
      out_time     <= '0;
      out_esum     <= '0;
    end else if (frame_done) begin
      out_valid    <= 1'b1;
      out_single   <= frame[FLAG_BIT];
      out_block_id <= frame[BLOCK_LSB +: BLOCK_W];
      out_energy   <= frame[ENERGY_LSB +: N_CHANNELS*ENERGY_W];
      out_time     <= frame[TIME_LSB +: TIME_W];
      out_esum     <= esum_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_singles_frame_decoder.sv
// Self-checking bench for singles_frame_decoder: directed scenarios plus a
// randomized stream, checked against a frame-level reference model.
`define CHK(tag, obs, exp) begin checks++; assert ((obs) === (exp)) passes++; else $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); end

module tb_singles_frame_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic        out_single;
  logic [5:0]  out_block_id;
  logic [95:0] out_energy;
  logic [19:0] out_time;
  logic [14:0] out_esum;
  logic        locked;
  logic [15:0] frame_errors;

  singles_frame_decoder #(
    .FRAME_BYTES (16),
    .LOCK_GOOD   (2),
    .LOCK_MISS   (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_single   (out_single),
    .out_block_id (out_block_id),
    .out_energy   (out_energy),
    .out_time     (out_time),
    .out_esum     (out_esum),
    .locked       (locked),
    .frame_errors (frame_errors)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int n_emitted = 0;
  bit gaps = 0;
  bit rand_ready = 0;
  logic        last_single;
  logic [14:0] last_esum;

  typedef struct {
    bit        single;
    bit [5:0]  blk;
    bit [95:0] energy;
    bit [19:0] tm;
    bit [14:0] esum;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;

  // Reference model: position within the current frame (-1 while hunting),
  // run lengths of good/missing headers, and whether lock was already held
  // when the current frame's header arrived.
  int        m_pos;
  int        m_good;
  int        m_miss;
  int        m_errs;
  bit        m_locked;
  bit        m_trusted;
  bit [127:0] m_buf;

  task automatic model_reset();
    m_pos = -1; m_good = 0; m_miss = 0; m_errs = 0;
    m_locked = 0; m_trusted = 0; m_buf = '0;
    exp_q.delete();
  endtask

  task automatic model_emit();
    exp_t x;
    int s = 0;
    x.single = m_buf[122];
    x.blk    = m_buf[121:116];
    x.energy = m_buf[115:20];
    x.tm     = m_buf[19:0];
    for (int i = 0; i < 8; i++) s += int'(m_buf[20 + 12*i +: 12]);
    x.esum = 15'(s);
    exp_q.push_back(x);
  endtask

  task automatic model_byte(input logic [7:0] b);
    bit hdr = (b[7:3] == 5'h1F);
    if (m_pos < 0) begin
      if (hdr) begin m_pos = 1; m_good = 1; m_buf = {120'b0, b}; end
    end else if (m_pos == 0) begin
      if (hdr) begin
        m_buf = {120'b0, b};
        m_pos = 1;
        if (m_locked) begin
          m_miss = 0; m_trusted = 1;
        end else begin
          m_good++;
          if (m_good == 2) begin m_locked = 1; m_trusted = 0; end
        end
      end else if (m_locked) begin
        if (m_errs < 65535) m_errs++;
        m_miss++;
        if (m_miss == 2) begin m_locked = 0; m_pos = -1; m_miss = 0; m_good = 0; m_trusted = 0; end
      end else begin
        m_pos = -1; m_good = 0;
      end
    end else begin
      m_buf = {m_buf[119:0], b};
      m_pos++;
      if (m_pos == 16) begin
        m_pos = 0;
        if (m_locked && m_trusted) model_emit();
      end
    end
  endtask

  function automatic logic [127:0] mk(input bit single, input logic [5:0] blk,
                                      input logic [95:0] en, input logic [19:0] tm);
    return {5'b11111, single, blk, en, tm};
  endfunction

  function automatic logic [127:0] rand_frame();
    logic [95:0] en = {$urandom, $urandom, $urandom};
    return mk(1'($urandom), 6'($urandom), en, 20'($urandom));
  endfunction

  function automatic logic [7:0] byte_of(input logic [127:0] f, input int k);
    return f[127 - 8*k -: 8];
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int unsigned waited = 0;
    bit acc = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 0;
        if (rand_ready) out_ready = 1'($urandom);
        @(posedge clk); #1;
      end
    end
    in_valid = 1;
    in_data  = b;
    while (!acc && waited < 200) begin
      if (rand_ready) out_ready = 1'($urandom);
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      waited++;
    end
    `CHK("byte_accept", acc, 1'b1)
    if (acc) model_byte(b);
  endtask

  task automatic send_bytes(input logic [127:0] f, input int from, input int to);
    for (int k = from; k <= to; k++) send_byte(byte_of(f, k));
  endtask

  task automatic drain();
    int unsigned n = 0;
    in_valid = 0; rand_ready = 0; gaps = 0; out_ready = 1;
    while (exp_q.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    `CHK("drain_queue", exp_q.size(), 0)
    `CHK("drain_out_valid", out_valid, 1'b0)
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 0;
    #2;
    `CHK("rst_out_valid", out_valid, 1'b0)
    `CHK("rst_out_single", out_single, 1'b0)
    `CHK("rst_block_id", out_block_id, 6'h0)
    `CHK("rst_energy", out_energy, 96'h0)
    `CHK("rst_time", out_time, 20'h0)
    `CHK("rst_esum", out_esum, 15'h0)
    `CHK("rst_locked", locked, 1'b0)
    `CHK("rst_frame_errors", frame_errors, 16'h0)
    `CHK("rst_in_ready", in_ready, 1'b1)
    model_reset();
    @(posedge clk); #1;
    rst = 0;
  endtask

  // Consumer-side monitor: every handshake must match the oldest expected frame.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      `CHK("emit_expected", exp_q.size() > 0, 1'b1)
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        `CHK("out_single", out_single, e.single)
        `CHK("out_block_id", out_block_id, e.blk)
        `CHK("out_energy", out_energy, e.energy)
        `CHK("out_time", out_time, e.tm)
        `CHK("out_esum", out_esum, e.esum)
      end
      n_emitted++;
      last_single = out_single;
      last_esum   = out_esum;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] f, fa, fb, fc, f6;
    logic [95:0]  en;
    int base;

    rst = 1; in_valid = 0; in_data = '0; out_ready = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Lock-up: three back-to-back frames, only the third is emitted.
    for (int k = 0; k < 8; k++) en[12*k +: 12] = 12'(k + 1);
    f = mk(1'b1, 6'h2A, en, 20'h12345);
    base = n_emitted;
    send_bytes(f, 0, 15);
    `CHK("lock_after_frame1", locked, 1'b0)
    send_bytes(f, 0, 0);
    `CHK("lock_after_header2", locked, 1'b1)
    send_bytes(f, 1, 15);
    send_bytes(f, 0, 15);
    drain();
    `CHK("lockup_emit_count", n_emitted - base, 1)
    `CHK("lockup_esum", last_esum, 15'd36)
    `CHK("lockup_errors", frame_errors, 16'h0)

    // Back-pressure: frame held with out_ready low, next frame waits.
    send_bytes(rand_frame(), 0, 15);
    drain();
    base = n_emitted;
    out_ready = 0;
    send_bytes(rand_frame(), 0, 15);
    `CHK("stall_out_valid_set", out_valid, 1'b1)
    f6 = rand_frame();
    in_valid = 1; in_data = byte_of(f6, 0);
    repeat (10) begin
      @(negedge clk);
      `CHK("stall_in_ready", in_ready, 1'b0)
      `CHK("stall_out_valid", out_valid, 1'b1)
      if (exp_q.size() != 0) begin
        `CHK("stall_block_id", out_block_id, exp_q[0].blk)
        `CHK("stall_energy", out_energy, exp_q[0].energy)
        `CHK("stall_time", out_time, exp_q[0].tm)
        `CHK("stall_esum", out_esum, exp_q[0].esum)
      end
      @(posedge clk); #1;
    end
    out_ready = 1;
    send_bytes(f6, 0, 15);
    drain();
    `CHK("stall_emit_count", n_emitted - base, 2)

    // Single corrupted header while locked.
    base = n_emitted;
    send_byte(8'h00);
    `CHK("corrupt_errors", frame_errors, 16'd1)
    `CHK("corrupt_locked", locked, 1'b1)
    send_bytes(rand_frame(), 0, 15);
    drain();
    `CHK("corrupt_emit_count", n_emitted - base, 1)
    `CHK("corrupt_errors_model", frame_errors, 16'(m_errs))

    // Two consecutive bad headers drop lock; relock needs two good headers.
    do_reset();
    fa = rand_frame(); fb = rand_frame(); fc = rand_frame();
    send_bytes(fa, 0, 15); send_bytes(fa, 0, 15); send_bytes(fb, 0, 15);
    drain();
    send_byte(8'h00);
    send_byte(8'h5A);
    `CHK("droplock_errors", frame_errors, 16'd2)
    `CHK("droplock_locked", locked, 1'b0)
    base = n_emitted;
    send_bytes(fa, 0, 15);
    `CHK("relock_after_one", locked, 1'b0)
    send_bytes(fb, 0, 0);
    `CHK("relock_after_two", locked, 1'b1)
    send_bytes(fb, 1, 15);
    send_bytes(fc, 0, 15);
    drain();
    `CHK("relock_emit_count", n_emitted - base, 1)

    // Time-tag frame with saturated energies.
    send_bytes(mk(1'b0, 6'h15, '1, 20'hABCDE), 0, 15);
    drain();
    `CHK("timetag_single", last_single, 1'b0)
    `CHK("timetag_esum", last_esum, 15'd32760)

    // Reset in the middle of a frame.
    f = rand_frame();
    send_bytes(f, 0, 6);
    in_data = byte_of(f, 7);
    do_reset();
    base = n_emitted;
    send_bytes(f, 7, 15);
    in_valid = 0;
    repeat (20) @(posedge clk);
    #1;
    `CHK("midrst_no_emit", n_emitted - base, 0)
    `CHK("midrst_out_valid", out_valid, 1'b0)
    `CHK("midrst_locked", locked, 1'b0)

    // Randomized stream with junk bytes, idle gaps and consumer stalls.
    gaps = 1; rand_ready = 1;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        repeat ($urandom_range(1, 2)) send_byte(8'($urandom_range(0, 247)));
      end
      send_bytes(rand_frame(), 0, 15);
      `CHK("rand_locked", locked, m_locked)
      `CHK("rand_errors", frame_errors, 16'(m_errs))
    end
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/singles_frame_decoder.md
SINGLES_FRAME_DECODER -- requirements
Module: singles_frame_decoder

Interface
REQ-001 Parameter FRAME_BYTES, default 16, meaning bytes per frame, MSB byte first.
REQ-002 Parameter LOCK_GOOD, default 2, meaning consecutive good headers required to lock.
REQ-003 Parameter LOCK_MISS, default 2, meaning consecutive bad headers that drop lock.
REQ-004 Port clk, input, 1, meaning single clock, all logic on rising edge.
REQ-005 Port rst, input, 1, meaning asynchronous, active-high reset.
REQ-006 Port in_data, input, 8, meaning link byte.
REQ-007 Port in_valid, input, 1, meaning in_data valid.
REQ-008 Port in_ready, output, 1, meaning byte accepted when in_valid & in_ready.
REQ-009 Port out_valid, output, 1, meaning decoded frame available.
REQ-010 Port out_ready, input, 1, meaning consumer accepts frame.
REQ-011 Port out_single, output, 1, meaning frame bit 122: 1 = single event, 0 = time tag.
REQ-012 Port out_block_id, output, 6, meaning frame bits [121:116].
REQ-013 Port out_energy, output, 96, meaning frame bits [115:20], eight 12-bit channels, A_FRONT in [11:0].
REQ-014 Port out_time, output, 20, meaning frame bits [19:0], {coarse[16:0], fine[2:0]}.
REQ-015 Port out_esum, output, 15, meaning unsigned sum of the eight energies.
REQ-016 Port locked, output, 1, meaning aligner in LOCKED.
REQ-017 Port frame_errors, output, 16, meaning count of bad headers seen while LOCKED, saturating.

Function
REQ-018 A header byte SHALL be one whose bits [7:3] equal 5'b11111; frame bit 127 maps to byte 0 bit 7.
REQ-019 The state machine SHALL have states HUNT, CHECK and LOCKED; a byte counter (0..FRAME_BYTES-1) SHALL track position.
REQ-020 HUNT: an accepted header byte SHALL start a frame at count 1 and move to CHECK with good=1; non-header bytes are discarded.
REQ-021 CHECK: at count 0, a header SHALL increment good and reach LOCKED when good==LOCK_GOOD; a non-header SHALL return to HUNT with good=0.
REQ-022 Frames completed in HUNT or CHECK SHALL NOT be emitted.
REQ-023 LOCKED: a non-header at count 0 SHALL be discarded, the counter held at 0, miss and frame_errors incremented; a header SHALL clear miss.
REQ-024 LOCKED: when miss reaches LOCK_MISS, the FSM SHALL enter HUNT and clear miss and good; frame_errors is retained.
REQ-025 In LOCKED, the cycle after the last byte of a frame is accepted, out_valid SHALL be 1 with all fields and out_esum registered.
REQ-026 Outputs SHALL hold stable while out_valid & ~out_ready; out_valid clears on out_valid & out_ready unless a new frame completes that cycle.
REQ-027 in_ready SHALL equal ~out_valid | out_ready, combinationally; no frame is ever dropped or overwritten.
REQ-028 out_esum SHALL be computed at full 15-bit width without overflow (max 8*4095 = 32760).
REQ-029 frame_errors SHALL saturate at 16'hFFFF.
REQ-030 Bytes SHALL only be consumed on in_valid & in_ready; in_valid low SHALL freeze the FSM and counter.

Reset
REQ-031 On rst, the FSM SHALL enter HUNT, counter/good/miss SHALL be 0, and out_valid, locked, frame_errors and all data outputs SHALL be 0.
REQ-032 A partial frame in progress when rst asserts SHALL be discarded; release SHALL resume in HUNT on the next edge.

Structure
REQ-033 A shared package SHALL hold the frame layout constants (FRAMING = 5'b11111, bit offsets for flag, block_id, energy and time, and ENERGY_W = 12), also used by the detector-side encoder.
REQ-034 One sub-module, frame_aligner, SHALL contain the HUNT/CHECK/LOCKED FSM and the counter; the top level holds the shift register, the output register and the sum.

Verification
REQ-035 Reset, then three back-to-back frames with block_id 6'h2A, energies 1..8 and time 20'h12345 -> locked rises after the 2nd header; exactly one frame is emitted, with out_esum = 36.
REQ-036 Locked, frame 5 with out_ready held low for 10 cycles -> in_ready = 0 and fields stable; the next frame is emitted intact after release.
REQ-037 Locked, one corrupted header byte 8'h00 followed by a valid frame -> frame_errors = 1, locked stays 1, and the valid frame is emitted.
REQ-038 Locked, two consecutive non-header bytes -> frame_errors = 2, locked = 0 and the FSM is in HUNT; relock needs 2 good headers.
REQ-039 Time-tag frame with flag 0 and energies all 12'hFFF -> out_single = 0 and out_esum = 32760.
REQ-040 rst asserted at byte 7 of a frame -> all outputs 0 immediately; after release, no partial frame is emitted.
